// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand bus for nibble_serial_adder_ctrl.
// Optional macro ADDER_SUB_EN adds the Sub request bit.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CarryIn;
`ifdef ADDER_SUB_EN
  logic         Sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         CarryOut;

`ifdef ADDER_SUB_EN
  modport master (
    output start, A, B, CarryIn, Sub,
    input  ready, busy, done, Sum, CarryOut
  );
  modport slave (
    input  start, A, B, CarryIn, Sub,
    output ready, busy, done, Sum, CarryOut
  );
`else
  modport master (
    output start, A, B, CarryIn,
    input  ready, busy, done, Sum, CarryOut
  );
  modport slave (
    input  start, A, B, CarryIn,
    output ready, busy, done, Sum, CarryOut
  );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one 4-bit slice, one nibble per clock, LSB nibble first.
// Optional macro ADDER_SUB_EN enables subtraction (A - B) through the Sub bit.

module binary_adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CarryIn,
  output logic [3:0] Sum,
  output logic       CarryOut
);
  logic [4:0] c;

  assign c[0] = CarryIn;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign Sum[gi]  = A[gi] ^ B[gi] ^ c[gi];
      assign c[gi+1]  = (A[gi] & B[gi]) | (c[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign CarryOut = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_adder_if.slave        bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];
  logic [3:0]      slice_a, slice_b, slice_sum;
  logic            slice_cout;

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  // Nibble mux built as a compare chain so every select is a constant part-select.
  always_comb begin
    slice_a = 4'h0;
    slice_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == i[IDXW-1:0]) begin
        slice_a = a_nib[i];
        slice_b = b_nib[i];
      end
    end
  end

  binary_adder_4_bit u_slice (
    .A        (slice_a),
    .B        (slice_b),
    .CarryIn  (carry_q),
    .Sum      (slice_sum),
    .CarryOut (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
`ifdef ADDER_SUB_EN
          // Two's complement subtract: invert B and force the initial carry.
          b_d     = bus.Sub ? ~bus.B : bus.B;
          carry_d = bus.Sub ? 1'b1 : bus.CarryIn;
`else
          b_d     = bus.B;
          carry_d = bus.CarryIn;
`endif
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == i[IDXW-1:0]) begin
            acc_d[4*i +: 4] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          // acc_d already holds this edge's nibble, so the published result is complete.
          sum_d   = acc_d;
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.Sum      = sum_q;
  assign bus.CarryOut = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4): vector table, corner sequences, random vs. arithmetic model.
module tb_nibble_serial_adder_ctrl;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [7];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on W+1 bits.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  task automatic set_sub(input logic s);
`ifdef ADDER_SUB_EN
    bus.Sub = s;
`else
    if (s) $display("[TB] note: Sub ignored in add-only build");
`endif
  endtask

  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input bit scramble, input string tag,
                        output logic [15:0] s_out, output logic c_out);
    logic [16:0] expv;
    logic [15:0] sum_before;
    logic        cout_before;
    int          n;
    int          busy_cnt;
    bit          stable;
    expv = model(a, b, cin, sub);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.CarryIn = cin; set_sub(sub); bus.start = 1'b1;
    sum_before  = bus.Sum;
    cout_before = bus.CarryOut;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.A = 16'($urandom); bus.B = 16'($urandom); bus.CarryIn = 1'($urandom);
`ifdef ADDER_SUB_EN
      bus.Sub = 1'($urandom);
`endif
    end
    n = 0; busy_cnt = 0; stable = 1'b1;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.Sum !== sum_before || bus.CarryOut !== cout_before) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(NIB));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(NIB));
    chk({tag, ".stable_while_busy"}, 64'(stable), 64'd1);
    chk({tag, ".sum"}, 64'(bus.Sum), 64'(expv[15:0]));
    chk({tag, ".cout"}, 64'(bus.CarryOut), 64'(expv[16]));
    s_out = bus.Sum;
    c_out = bus.CarryOut;
    @(posedge clk); #1;
    chk({tag, ".done_one_cycle"}, 64'(bus.done), 64'd0);
    chk({tag, ".ready_back"}, 64'(bus.ready), 64'd1);
    $display("[TB] %s A=%h B=%h cin=%0d sub=%0d -> Sum=%h Cout=%0d lat=%0d",
             tag, a, b, cin, sub, s_out, c_out, n);
  endtask

  initial begin
    logic [15:0] s;
    logic        c;
    int          dcount;
    int          last;
    int          gap_bad;
    int          n;
    bit          stab;
    bit          saw_done;
    logic [15:0] prev;

    vecs[0] = '{16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.CarryIn = 1'b0; set_sub(1'b0);
    #12;
    chk("reset.ready", 64'(bus.ready), 64'd1);
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.sum", 64'(bus.Sum), 64'd0);
    chk("reset.cout", 64'(bus.CarryOut), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, (i == 0), $sformatf("vec%0d", i), s, c);
      chk($sformatf("vec%0d.table_sum", i), 64'(s), 64'(vecs[i].sum));
      chk($sformatf("vec%0d.table_cout", i), 64'(c), 64'(vecs[i].cout));
    end

    // Reset while idle must clear the held result.
    @(negedge clk); rst = 1'b1; #2;
    chk("idle_rst.sum", 64'(bus.Sum), 64'd0);
    chk("idle_rst.ready", 64'(bus.ready), 64'd1);
    @(negedge clk); rst = 1'b0;

    // start held high: one accepted add per NIBBLES+2 cycles.
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h1111; bus.CarryIn = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    dcount = 0; last = -1; gap_bad = 0; stab = 1'b1; prev = bus.Sum;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (bus.busy && bus.Sum !== prev) stab = 1'b0;
      if (bus.done) begin
        dcount++;
        chk($sformatf("held.sum%0d", dcount), 64'(bus.Sum), 64'h2345);
        if (last >= 0 && (k - last) != NIB + 2) gap_bad++;
        last = k;
      end
      prev = bus.Sum;
    end
    chk("held.done_count", 64'(dcount), 64'd4);
    chk("held.gap_errors", 64'(gap_bad), 64'd0);
    chk("held.sum_stable", 64'(stab), 64'd1);
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (!bus.ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("held.drain_ready", 64'(bus.ready), 64'd1);
    $display("[TB] held-start: %0d done pulses", dcount);

    // Reset on the second RUN cycle: outputs clear at once, no done follows.
    @(negedge clk);
    bus.A = 16'h00FF; bus.B = 16'h0001; bus.CarryIn = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("midrst.ready", 64'(bus.ready), 64'd1);
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.sum", 64'(bus.Sum), 64'd0);
    chk("midrst.cout", 64'(bus.CarryOut), 64'd0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("midrst.no_done", 64'(saw_done), 64'd0);
    do_add(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, "after_rst", s, c);
    chk("after_rst.sum_const", 64'(s), 64'h0007);

`ifdef ADDER_SUB_EN
    do_add(16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, "sub0", s, c);
    chk("sub0.sum_const", 64'(s), 64'h000F);
    chk("sub0.cout_const", 64'(c), 64'd1);
    do_add(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, "sub1", s, c);
    chk("sub1.sum_const", 64'(s), 64'hFFFF);
    chk("sub1.cout_const", 64'(c), 64'd0);
`endif

    for (int r = 0; r < 40; r++) begin
`ifdef ADDER_SUB_EN
      do_add(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
             $sformatf("rnd%0d", r), s, c);
`else
      do_add(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1,
             $sformatf("rnd%0d", r), s, c);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
